// File: rtl/tt_um_example_vending_if.sv
// Pin bundle for the vending controller: the standard Tiny Tapeout user pins
// (enable, dedicated inputs/outputs, bidirectional in/out/oe).
interface tt_um_example_vending_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_example_vending.sv
// Coin-operated vending controller: accepts 5/10/25 coins, vends one of four
// items, returns change or refunds on cancel. Reset is active-high despite its name.
module tt_um_example_vending #(
  parameter int PRICE0  = 15,
  parameter int PRICE1  = 20,
  parameter int PRICE2  = 25,
  parameter int PRICE3  = 30,
  parameter int MAXCRED = 99
) (
  input logic                    clk,
  input logic                    rst_n,
  tt_um_example_vending_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [8:0] MAX_CREDIT = 9'(MAXCRED);

  state_t     state, state_next;
  logic [7:0] credit, credit_next;
  logic [1:0] item, item_next;
  logic       dispense, dispense_next;
  logic       change_valid, change_next;
  logic       error, error_next;

  // Control inputs are edge detected: {cancel, buy, coin25, coin10, coin5}.
  logic [4:0] ctrl, prev, rise;
  logic [7:0] price;
  logic [7:0] coin;
  logic       coin_hit;
  logic [8:0] sum;
  logic       busy;

  assign ctrl = {bus.ui_in[6], bus.ui_in[5], bus.ui_in[2:0]};
  assign rise = ctrl & ~prev;

  always_comb begin
    price = 8'(PRICE0);
    case (bus.ui_in[4:3])
      2'd0: price = 8'(PRICE0);
      2'd1: price = 8'(PRICE1);
      2'd2: price = 8'(PRICE2);
      2'd3: price = 8'(PRICE3);
      default: price = 8'(PRICE0);
    endcase
  end

  // Coin priority: 25 beats 10 beats 5 when several edges land together.
  always_comb begin
    coin     = 8'd0;
    coin_hit = 1'b1;
    if (rise[2])      coin = 8'd25;
    else if (rise[1]) coin = 8'd10;
    else if (rise[0]) coin = 8'd5;
    else              coin_hit = 1'b0;
  end

  assign sum = {1'b0, credit} + {1'b0, coin};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      credit       <= 8'd0;
      item         <= 2'd0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      error        <= 1'b0;
      prev         <= 5'd0;
    end else if (bus.ena) begin
      state        <= state_next;
      credit       <= credit_next;
      item         <= item_next;
      dispense     <= dispense_next;
      change_valid <= change_next;
      error        <= error_next;
      prev         <= ctrl;
    end
  end

  always_comb begin
    state_next    = state;
    credit_next   = credit;
    item_next     = item;
    dispense_next = 1'b0;
    change_next   = 1'b0;
    error_next    = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (rise[4]) begin
          if (credit != 8'd0) begin
            state_next  = CHANGE;
            change_next = 1'b1;
          end
        end else if (rise[3]) begin
          if (credit >= price) begin
            credit_next   = credit - price;
            item_next     = bus.ui_in[4:3];
            dispense_next = 1'b1;
            state_next    = VEND;
          end else begin
            error_next = 1'b1;
          end
        end else if (coin_hit) begin
          if (sum <= MAX_CREDIT) begin
            credit_next = sum[7:0];
            state_next  = COLLECT;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      VEND: begin
        if (credit != 8'd0) begin
          state_next  = CHANGE;
          change_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      CHANGE: begin
        credit_next = 8'd0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // In CHANGE the credit register still holds the amount being returned.
  assign busy        = (state == VEND) || (state == CHANGE);
  assign bus.uo_out  = credit;
  assign bus.uio_out = {state, busy, error, change_valid, item, dispense};
  assign bus.uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.uio_in, bus.ui_in[7]};

endmodule

// File: tb/tb_tt_um_example_vending.sv
// Scoreboard bench for the vending controller: directed scenarios plus random
// pin activity, checked against a credit/phase reference model.
module tb_tt_um_example_vending;

  logic clk = 1'b0;
  logic rst_n;

  tt_um_example_vending_if bus ();

  tt_um_example_vending dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: credit as an int, phase 0 = taking coins, 2 = vending, 3 = returning change.
  int         price_tab[4] = '{15, 20, 25, 30};
  int         m_credit = 0;
  int         m_phase  = 0;
  int         m_item   = 0;
  bit         m_disp = 0, m_cv = 0, m_err = 0;
  logic [7:0] m_prev = '0;

  localparam logic [7:0] C5 = 8'h01, C10 = 8'h02, C25 = 8'h04, BUY = 8'h20, CANCEL = 8'h40;

  function automatic logic [7:0] sel(input int s);
    return 8'(s << 3);
  endfunction

  task automatic model_step(input logic [7:0] ui, input logic en, input logic rs);
    logic [7:0] rise;
    int v, p;
    if (rs) begin
      m_credit = 0; m_phase = 0; m_item = 0;
      m_disp = 0; m_cv = 0; m_err = 0; m_prev = '0;
      return;
    end
    if (!en) return;
    rise = ui & ~m_prev;
    m_prev = ui;
    m_disp = 0; m_cv = 0; m_err = 0;
    if (m_phase == 2) begin
      m_phase = (m_credit > 0) ? 3 : 0;
      m_cv = (m_credit > 0);
    end else if (m_phase == 3) begin
      m_credit = 0;
      m_phase = 0;
    end else if (rise[6]) begin
      if (m_credit > 0) begin m_phase = 3; m_cv = 1; end
    end else if (rise[5]) begin
      p = price_tab[ui[4:3]];
      if (m_credit >= p) begin
        m_credit -= p; m_item = int'(ui[4:3]); m_phase = 2; m_disp = 1;
      end else m_err = 1;
    end else if (rise[2] || rise[1] || rise[0]) begin
      v = rise[2] ? 25 : (rise[1] ? 10 : 5);
      if (m_credit + v <= 99) m_credit += v;
      else m_err = 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int st;
    st = (m_phase != 0) ? m_phase : ((m_credit > 0) ? 1 : 0);
    e.uo  = 8'(m_credit);
    e.uio = {2'(st), (m_phase != 0), m_err, m_cv, 2'(m_item), m_disp};
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] ui, input logic en, input logic rs);
    @(negedge clk);
    bus.ui_in = ui;
    bus.ena   = en;
    rst_n     = rs;
    model_step(ui, en, rs);
    exp_q.push_back(model_out());
  endtask

  task automatic pulse(input logic [7:0] ui);
    applyStimulus(ui, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (bus.uo_out !== e.uo || bus.uio_out !== e.uio) begin
      mismatched++;
      $display("[TB] FAIL pins @%0t: uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
               $time, bus.uo_out, bus.uio_out, e.uo, e.uio);
    end
  endtask

  // Monitor: after every edge the DUT presents a new pin state; pop its expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      else if (bus.uio_out[0] === 1'b1 || bus.uio_out[3] === 1'b1 || bus.uio_out[4] === 1'b1) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: uio_out=%h with no expectation queued", bus.uio_out);
      end
    end
  end

  initial begin
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b1;

    // Reset held two cycles.
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(C25, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    compared++;
    if (bus.uio_oe !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL uio_oe: got %h, expected ff", bus.uio_oe);
    end

    $display("[TB] exact-price purchase");
    pulse(C10); pulse(C10); pulse(BUY | sel(1));
    applyStimulus(8'h00, 1'b1, 1'b0);

    $display("[TB] purchase with change");
    pulse(C25); pulse(BUY | sel(0));
    applyStimulus(8'h00, 1'b1, 1'b0);

    $display("[TB] insufficient credit, then cancel");
    pulse(C5); pulse(BUY | sel(3)); pulse(CANCEL);
    applyStimulus(8'h00, 1'b1, 1'b0);
    pulse(CANCEL);

    $display("[TB] credit ceiling");
    repeat (4) pulse(C25);
    pulse(C10);
    pulse(C25);
    pulse(CANCEL);
    applyStimulus(8'h00, 1'b1, 1'b0);

    $display("[TB] held input, simultaneous coins, ena low");
    repeat (5) applyStimulus(C5, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    pulse(C25 | C5);
    applyStimulus(C10, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    $display("[TB] reset during vend");
    pulse(C25);
    applyStimulus(BUY | sel(1), 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);

    $display("[TB] random activity");
    for (int i = 0; i < 800; i++) begin
      logic [7:0] ui;
      ui = {1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0)};
      applyStimulus(ui, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 2));
    end

    @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
